// File: rtl/csi_ltf_averager.sv
// Pairwise average of the two LTF symbols' per-subcarrier CSI products, followed by a
// rescale and saturate, streamed out as one channel estimate per subcarrier.
`timescale 1ns/1ps
module csi_ltf_averager #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned NUM_SC     = 64,
    parameter int unsigned SHIFT      = 14
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         frame_start_in,
    input  logic signed [DATA_WIDTH-1:0] i_in,
    input  logic signed [DATA_WIDTH-1:0] q_in,
    input  logic                         valid_in,
    output logic signed [OUT_WIDTH-1:0]  i_out,
    output logic signed [OUT_WIDTH-1:0]  q_out,
    output logic [$clog2(NUM_SC)-1:0]    sc_idx_out,
    output logic                         valid_out,
    output logic                         last_out,
    output logic                         done_out,
    output logic                         busy_out
);
    localparam int unsigned IdxW = $clog2(NUM_SC);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SC - 1);

    typedef enum logic [1:0] {StIdle, StSym0, StSym1, StFlush} state_e;

    state_e                        state_q, state_d;
    logic [IdxW-1:0]               cnt_q, cnt_d;
    logic                          accept, wr_en, sym1_en;
    logic signed [DATA_WIDTH-1:0]  mem_i [NUM_SC];
    logic signed [DATA_WIDTH-1:0]  mem_q [NUM_SC];
    logic signed [DATA_WIDTH-1:0]  rd_i_q, rd_q_q, s1_i_q, s1_q_q;
    logic                          s1_valid_q, s1_last_q;
    logic [IdxW-1:0]               s1_idx_q;
    logic signed [DATA_WIDTH:0]    sum_i, sum_q;
    logic signed [OUT_WIDTH-1:0]   res_i, res_q;
    logic signed [OUT_WIDTH-1:0]   i_q, q_q;
    logic [IdxW-1:0]               idx_q;
    logic                          valid_q, last_q, done_q;

    // Clamp when the bits above the output sign bit are not a pure sign extension.
    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH:0] x);
        logic [DATA_WIDTH-OUT_WIDTH+1:0] top;
        top = x[DATA_WIDTH:OUT_WIDTH-1];
        if ((&top) || !(|top)) return x[OUT_WIDTH-1:0];
        return x[DATA_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (frame_start_in) begin
            state_d = StSym0;
            cnt_d   = '0;
        end else begin
            if (accept) cnt_d = (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StSym0:  if (accept && cnt_q == LastIdx) state_d = StSym1;
                StSym1:  if (accept && cnt_q == LastIdx) state_d = StFlush;
                StFlush: if (done_q) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        accept   = valid_in && !frame_start_in && (state_q == StSym0 || state_q == StSym1);
        wr_en    = accept && (state_q == StSym0);
        sym1_en  = accept && (state_q == StSym1);
        busy_out = (state_q != StIdle);
    end

    // Symbol-0 store; contents are deliberately left unreset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_i[cnt_q] <= i_in;
            mem_q[cnt_q] <= q_in;
        end
        if (sym1_en) begin
            rd_i_q <= mem_i[cnt_q];
            rd_q_q <= mem_q[cnt_q];
        end
    end

    always_comb begin
        sum_i = {rd_i_q[DATA_WIDTH-1], rd_i_q} + {s1_i_q[DATA_WIDTH-1], s1_i_q};
        sum_q = {rd_q_q[DATA_WIDTH-1], rd_q_q} + {s1_q_q[DATA_WIDTH-1], s1_q_q};
        // Halving and rescale folded into one arithmetic (floor) shift.
        res_i = saturate(sum_i >>> (SHIFT + 1));
        res_q = saturate(sum_q >>> (SHIFT + 1));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_idx_q   <= '0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            i_q        <= '0;
            q_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            s1_valid_q <= sym1_en;
            s1_last_q  <= sym1_en && (cnt_q == LastIdx);
            if (sym1_en) begin
                s1_idx_q <= cnt_q;
                s1_i_q   <= i_in;
                s1_q_q   <= q_in;
            end
            valid_q <= s1_valid_q;
            last_q  <= s1_last_q;
            if (s1_valid_q) begin
                idx_q <= s1_idx_q;
                i_q   <= res_i;
                q_q   <= res_q;
            end
            done_q <= valid_q && last_q;
        end
    end

    assign i_out      = i_q;
    assign q_out      = q_q;
    assign sc_idx_out = idx_q;
    assign valid_out  = valid_q;
    assign last_out   = last_q;
    assign done_out   = done_q;

endmodule

// File: tb/tb_csi_ltf_averager.sv
// Scoreboard bench: two averager instances (SHIFT 0 and SHIFT 14, four subcarriers) share one
// directed input stream; a negedge monitor checks every output against hand-computed entries.
`timescale 1ns/1ps
module tb_csi_ltf_averager;
    localparam int unsigned DW  = 32;
    localparam int unsigned OW  = 16;
    localparam int unsigned NSC = 4;

    typedef int vec4_t [4];
    typedef struct {
        int         cyc;
        logic [1:0] idx;
        logic       last;
        int         ai, aq, bi, bq;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, frame_start, valid;
    logic signed [DW-1:0] din_i, din_q;
    logic signed [OW-1:0] a_i, a_q, b_i, b_q;
    logic [1:0]           a_idx, b_idx;
    logic a_valid, a_last, a_done, a_busy;
    logic b_valid, b_last, b_done, b_busy;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t expq[$];
    exp_t e;
    logic done_pend = 1'b0;

    // Frames: 0 basic, 1 saturate/scale, 2 extremes, 3 aborted, 4 post-abort, 5 drop-on-start
    vec4_t s0i[6] = '{'{100, -100, 7, -7}, '{40000, -40000, 49152, -1},
                      '{2147483647, -2147483647 - 1, 1000, 0}, '{1000, 2000, 3000, 4000},
                      '{10, 20, 30, 40}, '{5, -5, 1, -1}};
    vec4_t s0q[6] = '{'{100, -100, 7, -7}, '{-5, 6, 1, 32767}, '{0, 0, 16384, -16384},
                      '{-1000, -2000, -3000, -4000}, '{-10, -20, -30, -40}, '{0, 2, 4, 6}};
    vec4_t s1i[6] = '{'{200, -300, 8, -8}, '{40000, -40000, 49152, -1},
                      '{2147483647, -2147483647 - 1, -1000, 1}, '{1000, 2000, 0, 0},
                      '{30, 40, 50, 60}, '{7, -7, -1, 1}};
    vec4_t s1q[6] = '{'{200, -300, 8, -8}, '{-5, 6, 1, 32767}, '{0, 1, 16384, -16385},
                      '{-1000, -2000, 0, 0}, '{-30, -40, -50, -60}, '{2, 4, 6, 8}};
    vec4_t eai[6] = '{'{150, -200, 7, -8}, '{32767, -32768, 32767, -1},
                      '{32767, -32768, 0, 0}, '{1000, 2000, 0, 0}, '{20, 30, 40, 50},
                      '{6, -6, 0, 0}};
    vec4_t eaq[6] = '{'{150, -200, 7, -8}, '{-5, 6, 1, 32767}, '{0, 0, 16384, -16385},
                      '{-1000, -2000, 0, 0}, '{-20, -30, -40, -50}, '{1, 3, 5, 7}};
    vec4_t ebi[6] = '{'{0, -1, 0, -1}, '{2, -3, 3, -1}, '{32767, -32768, 0, 0},
                      '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, -1, 0, 0}};
    vec4_t ebq[6] = '{'{0, -1, 0, -1}, '{-1, 0, 0, 1}, '{0, 0, 1, -2},
                      '{-1, -1, 0, 0}, '{-1, -1, -1, -1}, '{0, 0, 0, 0}};

    csi_ltf_averager #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_SC(NSC), .SHIFT(0)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start),
        .i_in(din_i), .q_in(din_q), .valid_in(valid),
        .i_out(a_i), .q_out(a_q), .sc_idx_out(a_idx), .valid_out(a_valid),
        .last_out(a_last), .done_out(a_done), .busy_out(a_busy)
    );

    csi_ltf_averager #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_SC(NSC), .SHIFT(14)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start),
        .i_in(din_i), .q_in(din_q), .valid_in(valid),
        .i_out(b_i), .q_out(b_q), .sc_idx_out(b_idx), .valid_out(b_valid),
        .last_out(b_last), .done_out(b_done), .busy_out(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            done_pend = 1'b0;
        end else begin
            if (done_pend || a_done || b_done) begin
                n_vec++;
                if (a_done !== done_pend || b_done !== done_pend) begin
                    n_fail++;
                    $display("FAIL done_pulse cyc=%0d: got a=%b b=%b, want %b",
                             cyc, a_done, b_done, done_pend);
                end
            end
            done_pend = 1'b0;
            if (a_valid || b_valid) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out cyc=%0d: got a_v=%b b_v=%b, want none",
                             cyc, a_valid, b_valid);
                end else begin
                    e = expq.pop_front();
                    done_pend = e.last;
                    if (cyc != e.cyc || a_valid !== 1'b1 || b_valid !== 1'b1 ||
                        a_idx !== e.idx || b_idx !== e.idx ||
                        a_last !== e.last || b_last !== e.last ||
                        a_i != e.ai || a_q != e.aq || b_i != e.bi || b_q != e.bq) begin
                        n_fail++;
                        $display({"FAIL out_cmp: got cyc=%0d A(v%b i%0d q%0d idx%0d l%b) ",
                                  "B(v%b i%0d q%0d idx%0d l%b) want cyc=%0d idx%0d l%b ",
                                  "A(i%0d q%0d) B(i%0d q%0d)"},
                                 cyc, a_valid, a_i, a_q, a_idx, a_last,
                                 b_valid, b_i, b_q, b_idx, b_last,
                                 e.cyc, e.idx, e.last, e.ai, e.aq, e.bi, e.bq);
                    end
                end
            end
        end
    end

    task automatic check_busy(input logic want, input string name);
        n_vec++;
        if (a_busy !== want || b_busy !== want) begin
            n_fail++;
            $display("FAIL %s: got busy a=%b b=%b, want %b", name, a_busy, b_busy, want);
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({a_i, a_q, a_idx, a_valid, a_last, a_done, a_busy} !== '0 ||
            {b_i, b_q, b_idx, b_valid, b_last, b_done, b_busy} !== '0) begin
            n_fail++;
            $display("FAIL %s: got a_v=%b a_i=%0d b_v=%b b_i=%0d busy=%b/%b, want all zero",
                     name, a_valid, a_i, b_valid, b_i, a_busy, b_busy);
        end
    endtask

    // Starts at posedge+1; leaves at posedge+1 right after the last sample is captured.
    task automatic run_frame(input int f, input int gap_max, input int n_sym1, input bit fs_valid);
        int   g;
        int   j;
        exp_t x;
        frame_start = 1'b1;
        valid       = fs_valid;
        din_i       = 30000;
        din_q       = 30000;
        @(posedge clk); #1;
        frame_start = 1'b0;
        valid       = 1'b0;
        check_busy(1'b1, "busy_after_start");
        for (int k = 0; k < int'(NSC) + n_sym1; k++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(posedge clk); #1;
            end
            valid = 1'b1;
            if (k < int'(NSC)) begin
                din_i = s0i[f][k];
                din_q = s0q[f][k];
            end else begin
                j      = k - int'(NSC);
                din_i  = s1i[f][j];
                din_q  = s1q[f][j];
                x.cyc  = cyc + 2;
                x.idx  = 2'(j);
                x.last = (j == int'(NSC) - 1);
                x.ai   = eai[f][j];
                x.aq   = eaq[f][j];
                x.bi   = ebi[f][j];
                x.bq   = ebq[f][j];
                expq.push_back(x);
            end
            @(posedge clk); #1;
            valid = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        valid       = 1'b0;
        din_i       = '0;
        din_q       = '0;
        #12;
        check_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_busy(1'b0, "idle_after_reset");

        run_frame(0, 0, 4, 1'b0);
        run_frame(1, 0, 4, 1'b0);
        run_frame(2, 0, 4, 1'b0);
        run_frame(0, 5, 4, 1'b0);
        run_frame(3, 0, 2, 1'b0);
        run_frame(4, 3, 4, 1'b0);
        run_frame(5, 0, 4, 1'b1);

        // Three symbol-1 samples in, output for sample 1 on the bus, then reset.
        run_frame(1, 0, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset_mid_sym1");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_busy(1'b0, "idle_after_midreset");
        repeat (3) begin
            @(posedge clk); #1;
        end

        run_frame(0, 0, 4, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_busy(1'b1, "busy_at_done");
        @(posedge clk); #1;
        check_busy(1'b0, "busy_after_done");
        repeat (4) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL missing_outputs: got %0d still pending, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
